// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-deep valid/ready output register.
// The rx pin is oversampled at the system clock, double-synchronized, and each
// bit is sampled at the centre of its cell. The stop bit is checked: a low stop
// bit gives a framing-error pulse. A byte that completes while the holding
// register is still full gives an overrun pulse.
module uart_rx #(
  parameter int MAIN_CLK = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_err,
  output logic       overrun
);

  // Clocks per bit cell and half cell; the start bit is qualified mid-cell.
  localparam int CPB  = MAIN_CLK / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TW   = (CPB > 2) ? $clog2(CPB) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CPB - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  // Receiver states.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          r_sync1;
  logic          r_rx_s;
  logic [2:0]    r_state;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;

  logic          w_tick_last;
  logic          w_tick_half;
  logic          w_stop_edge;
  logic          w_deliver;
  logic          w_frame_bad;
  logic          w_accept;
  logic          w_load;

  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_tick_half = (r_tick == TICK_HALF);

  // The stop bit is judged on the last tick of its cell.
  assign w_stop_edge = (r_state == S_STOP) && w_tick_last;
  assign w_deliver   = w_stop_edge && r_rx_s;
  assign w_frame_bad = w_stop_edge && !r_rx_s;

  // The consumer takes the current byte this edge.
  assign w_accept    = r_valid && data_out_ready;

  // A new byte may be loaded if the holder is empty or is being emptied now.
  assign w_load      = w_deliver && (!r_valid || data_out_ready);

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign frame_err      = r_frame_err;
  assign overrun        = r_overrun;

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  // Frame sequencer: start qualification, bit timing and stop/break handling.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_tick  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick_half) begin
            if (!r_rx_s) begin
              r_tick   <= '0;
              r_bitcnt <= '0;
              r_state  <= S_DATA;
            end else begin
              // Line went back high before mid-cell: a glitch, not a start bit.
              r_state <= S_IDLE;
            end
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        S_DATA: begin
          if (w_tick_last) begin
            r_tick   <= '0;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        S_STOP: begin
          if (w_tick_last) begin
            r_tick  <= '0;
            // Returning to IDLE on the stop sample keeps back-to-back frames
            // aligned; a low stop waits out the held-low line in BREAK.
            r_state <= r_rx_s ? S_IDLE : S_BREAK;
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

  // Shift register: capture each data bit, LSB first, at its cell centre.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_shift <= 8'h00;
    end else if ((r_state == S_DATA) && w_tick_last) begin
      r_shift[r_bitcnt] <= r_rx_s;
    end
  end

  // Output holding register with valid/ready handshake and error pulses.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= w_deliver && !w_load;
      if (w_load) begin
        // Covers the simultaneous accept-and-deliver case: valid stays high.
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed bench for uart_rx (CPB=16, HALF=8).
// A frame-level model predicts, from each driven frame's start time, the edge
// at which its byte or framing error must appear, then applies the holding-
// register rules against the actual ready line every cycle.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.MAIN_CLK(16), .BAUD(1)) dut (
    .clk            (clk),
    .reset_         (reset_),
    .rx             (rx),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_err      (frame_err),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } ob_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  ev_t  ev_q[$];
  ob_t  obs_q[$];

  // Model of the output side.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  // Observation counters.
  int   vhigh_cnt = 0;
  int   ferr_cnt  = 0;
  int   ovr_cnt   = 0;
  int   ovr_last  = -1;
  logic prev_v    = 1'b0;

  // Ready control.
  bit   rand_ready  = 1'b0;
  bit   ready_force = 1'b0;
  int   ready_at    = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs_data(input int i);
    if (i < obs_q.size()) return {24'h0, obs_q[i].data};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] obs_cyc(input int i);
    if (i < obs_q.size()) return obs_q[i].cyc;
    return 32'hFFFF_FFFF;
  endfunction

  // Model: advance on every rising edge.
  initial begin
    forever begin
      bit  acc;
      ev_t e;
      @(posedge clk);
      cyc = cyc + 1;
      if (!reset_) begin
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        ev_q.delete();
      end else begin
        acc    = m_valid && data_out_ready;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
          e = ev_q.pop_front();
          if (!e.good) begin
            m_ferr = 1'b1;
            if (acc) m_valid = 1'b0;
          end else if (!m_valid || data_out_ready) begin
            m_data  = e.data;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (acc) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare process: check every output on every falling edge, and log.
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (data_out !== m_data || data_out_valid !== m_valid ||
          frame_err !== m_ferr || overrun !== m_ovr) begin
        fails++;
        if (fails < 30)
          $display("FAIL cycle %0d: dut data=%h v=%b fe=%b ov=%b, model data=%h v=%b fe=%b ov=%b",
                   cyc, data_out, data_out_valid, frame_err, overrun,
                   m_data, m_valid, m_ferr, m_ovr);
      end
      if (data_out_valid === 1'b1 && prev_v !== 1'b1) obs_q.push_back('{cyc, data_out});
      if (data_out_valid === 1'b1) vhigh_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) begin
        ovr_cnt++;
        ovr_last = cyc;
      end
      prev_v = data_out_valid;
    end
  end

  // Ready driver: changes only on falling edges.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) data_out_ready = 1'($urandom_range(0, 1));
      else            data_out_ready = ready_force || (cyc == ready_at);
    end
  end

  // Drive one 8N1 frame; the next call starts exactly one frame later.
  task automatic send_frame(input logic [7:0] b, input bit stopb, output int p);
    @(negedge clk);
    p = cyc;
    ev_q.push_back('{p + LAT, stopb, b});
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopb;
    repeat (CPB - 1) @(negedge clk);
  endtask

  initial begin
    int         p, p1, p2, f0, o0, v0, g;
    logic [7:0] b;
    bit         bad;

    ready_force = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_ = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame with rx toggling.
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (30) begin
      @(negedge clk);
      rx = 1'($urandom_range(0, 1));
    end
    #2 reset_ = 1'b0;
    @(negedge clk);
    check("reset_data", {24'h0, data_out}, 32'h00);
    check("reset_valid", {31'h0, data_out_valid}, 32'h0);
    check("reset_ferr", {31'h0, frame_err}, 32'h0);
    check("reset_ovr", {31'h0, overrun}, 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_ = 1'b1;
    obs_q.delete();
    repeat (200) @(negedge clk);
    check("reset_no_byte", obs_q.size(), 32'd0);
    check("reset_no_ferr", ferr_cnt - f0, 32'd0);

    // Single byte 0x55 with ready high.
    obs_q.delete();
    v0 = vhigh_cnt;
    send_frame(8'h55, 1'b1, p);
    repeat (20) @(negedge clk);
    check("single_count", obs_q.size(), 32'd1);
    check("single_latency", obs_cyc(0) - p, 32'd155);
    check("single_data", obs_data(0), 32'h55);
    check("single_width", vhigh_cnt - v0, 32'd1);

    // Back-to-back sequence.
    obs_q.delete();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send_frame(8'h03, 1'b1, p);
    send_frame(8'h76, 1'b1, p);
    send_frame(8'h48, 1'b1, p);
    send_frame(8'h83, 1'b1, p);
    repeat (20) @(negedge clk);
    check("b2b_count", obs_q.size(), 32'd4);
    check("b2b_d0", obs_data(0), 32'h03);
    check("b2b_d1", obs_data(1), 32'h76);
    check("b2b_d2", obs_data(2), 32'h48);
    check("b2b_d3", obs_data(3), 32'h83);
    check("b2b_gap1", obs_cyc(1) - obs_cyc(0), 32'd160);
    check("b2b_gap2", obs_cyc(2) - obs_cyc(1), 32'd160);
    check("b2b_gap3", obs_cyc(3) - obs_cyc(2), 32'd160);
    check("b2b_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

    // Overrun with ready held low.
    ready_force = 1'b0;
    repeat (2) @(negedge clk);
    o0 = ovr_cnt;
    send_frame(8'hDE, 1'b1, p1);
    send_frame(8'hAD, 1'b1, p2);
    repeat (20) @(negedge clk);
    check("ovr_data", {24'h0, data_out}, 32'hDE);
    check("ovr_valid", {31'h0, data_out_valid}, 32'h1);
    check("ovr_count", ovr_cnt - o0, 32'd1);
    check("ovr_when", ovr_last - p2, 32'd155);
    ready_force = 1'b1;
    repeat (3) @(negedge clk);
    ready_force = 1'b0;
    repeat (3) @(negedge clk);

    // Same again, but ready pulses on the second byte's delivery edge.
    o0 = ovr_cnt;
    ready_at = cyc + 1 + 160 + LAT - 1;
    send_frame(8'hDE, 1'b1, p1);
    send_frame(8'hAD, 1'b1, p2);
    repeat (20) @(negedge clk);
    check("simul_data", {24'h0, data_out}, 32'hAD);
    check("simul_valid", {31'h0, data_out_valid}, 32'h1);
    check("simul_no_ovr", ovr_cnt - o0, 32'd0);
    ready_at = -1;
    ready_force = 1'b1;
    repeat (5) @(negedge clk);

    // Framing error, held-low line, then a good byte.
    obs_q.delete();
    f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0, p);
    repeat (41) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'hAA, 1'b1, p);
    repeat (20) @(negedge clk);
    check("ferr_count", ferr_cnt - f0, 32'd1);
    check("ferr_bytes", obs_q.size(), 32'd1);
    check("ferr_next", obs_data(0), 32'hAA);

    // Glitch rejection.
    obs_q.delete();
    f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'h03, 1'b1, p);
    repeat (20) @(negedge clk);
    check("glitch_ferr", ferr_cnt - f0, 32'd0);
    check("glitch_bytes", obs_q.size(), 32'd1);
    check("glitch_next", obs_data(0), 32'h03);

    // Randomized frames, gaps, stop bits and ready.
    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, p);
      g = $urandom_range(0, 20);
      if (bad) g = g + 4;
      if (g > 0) begin
        @(negedge clk);
        rx = 1'b1;
        repeat (g - 1) @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rand_ready = 1'b0;
    ready_force = 1'b1;
    repeat (200) @(negedge clk);
    check("final_queue_drained", ev_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
